// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). Consumes one magnitude bit per clock and
// presents packed BCD digits plus a sign flag using a start/busy/done handshake.
module bin2bcd_seq #(
  parameter int unsigned width  = 8,
  parameter int unsigned digits = 3
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [width-1:0]    data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                neg_o,
  output logic [4*digits-1:0] bcd_o
);

  localparam int unsigned BcdW = 4 * digits;
  localparam int unsigned CntW = $clog2(width + 1);

  function automatic bit range_ok();
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return p > (longint'(1) << width);
  endfunction

  if (!range_ok()) begin : g_bad_range
    $error("bin2bcd_seq: digits too small to represent every width-bit magnitude");
  end

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e            state_q, state_d;
  logic [width-1:0]  mag_q, mag_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic [BcdW-1:0]   adjusted;
  logic [BcdW-1:0]   shifted;
  logic              in_neg;

  // Every digit >= 5 is corrected before the shift so it carries correctly into the next digit.
  function automatic logic [BcdW-1:0] add3(input logic [BcdW-1:0] s);
    logic [BcdW-1:0] r;
    r = s;
    for (int i = 0; i < int'(digits); i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    adjusted  = add3(scratch_q);
    shifted   = {adjusted[BcdW-2:0], mag_q[width-1]};
    in_neg    = signed_i & data_i[width-1];

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          // Width-bit negate keeps the most negative value correct (e.g. 8'h80 -> 128).
          mag_d     = in_neg ? (~data_i + 1'b1) : data_i;
          sign_d    = in_neg;
          scratch_d = '0;
          cnt_d     = CntW'(width);
          state_d   = StConvert;
        end else begin
          state_d   = StIdle;
        end
      end
      StConvert: begin
        scratch_d = shifted;
        mag_d     = mag_q << 1;
        cnt_d     = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          bcd_d   = shifted;
          neg_d   = sign_q;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
    end
  end

  assign busy_o = (state_q == StConvert);
  assign done_o = (state_q == StDone);
  assign neg_o  = neg_q;
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, handshake corner cases, async reset abort,
// a 16-bit instance, and random vectors checked against a decimal-string reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, sig8 = 1'b0;
  logic [7:0]  data8 = '0;
  logic        busy8, done8, neg8;
  logic [11:0] bcd8;

  logic        start16 = 1'b0, sig16 = 1'b0;
  logic [15:0] data16 = '0;
  logic        busy16, done16, neg16;
  logic [19:0] bcd16;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.width(8), .digits(3)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .signed_i(sig8), .data_i(data8),
    .busy_o(busy8), .done_o(done8), .neg_o(neg8), .bcd_o(bcd8)
  );

  bin2bcd_seq #(.width(16), .digits(5)) u_dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start16), .signed_i(sig16), .data_i(data16),
    .busy_o(busy16), .done_o(done16), .neg_o(neg16), .bcd_o(bcd16)
  );

  typedef struct {
    bit         sig;
    logic [7:0] data;
    logic [11:0] exp_bcd;
    bit         exp_neg;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Reference: decimal text of the magnitude, one nibble per character.
  function automatic logic [19:0] dec_to_bcd(input longint unsigned v);
    string s;
    logic [19:0] r;
    s = $sformatf("%0d", v);
    r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[15:0], 4'(s[i] - 8'h30)};
    return r;
  endfunction

  // Renders the DUT result as a signed decimal string with leading zeros removed.
  function automatic string bcd_to_str(input logic [19:0] bcd, input logic neg, input int nd);
    string s;
    bit lead;
    s = "";
    lead = 1'b1;
    for (int i = nd - 1; i >= 0; i--) begin
      if (!(lead && bcd[4*i +: 4] == 4'd0 && i != 0)) begin
        lead = 1'b0;
        s = {s, string'(8'(8'h30 + bcd[4*i +: 4]))};
      end
    end
    return neg ? {"-", s} : s;
  endfunction

  task automatic do_conv(input bit wide, input bit s, input logic [15:0] d,
                         output logic [19:0] bcd, output logic neg, output int lat);
    logic [19:0] held;
    bit moved;
    @(negedge clk);
    if (wide) begin start16 = 1'b1; sig16 = s; data16 = d; end
    else      begin start8  = 1'b1; sig8  = s; data8  = d[7:0]; end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    // Inputs after the accepting edge must not matter.
    data8   = 8'($urandom);
    data16  = 16'($urandom);
    sig8    = ~sig8;
    sig16   = ~sig16;
    held  = wide ? bcd16 : {8'h0, bcd8};
    moved = 1'b0;
    lat   = 0;
    while (!(wide ? done16 : done8) && lat < 40) begin
      @(negedge clk);
      lat++;
      if ((wide ? busy16 : busy8) && held != (wide ? bcd16 : {8'h0, bcd8})) moved = 1'b1;
    end
    bcd = wide ? bcd16 : {8'h0, bcd8};
    neg = wide ? neg16 : neg8;
    check("hold_while_busy", 64'(moved), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(wide ? done16 : done8), 64'd0);
  endtask

  initial begin
    vec_t        tbl[8];
    logic [19:0] r_bcd;
    logic        r_neg;
    int          lat;
    int          k;
    bit          seen;

    tbl[0] = '{sig: 1'b0, data: 8'd255, exp_bcd: 12'h255, exp_neg: 1'b0};
    tbl[1] = '{sig: 1'b1, data: 8'h80,  exp_bcd: 12'h128, exp_neg: 1'b1};
    tbl[2] = '{sig: 1'b1, data: 8'hFF,  exp_bcd: 12'h001, exp_neg: 1'b1};
    tbl[3] = '{sig: 1'b1, data: 8'h00,  exp_bcd: 12'h000, exp_neg: 1'b0};
    tbl[4] = '{sig: 1'b0, data: 8'h80,  exp_bcd: 12'h128, exp_neg: 1'b0};
    tbl[5] = '{sig: 1'b1, data: 8'h7F,  exp_bcd: 12'h127, exp_neg: 1'b0};
    tbl[6] = '{sig: 1'b1, data: 8'hD6,  exp_bcd: 12'h042, exp_neg: 1'b1};
    tbl[7] = '{sig: 1'b0, data: 8'd9,   exp_bcd: 12'h009, exp_neg: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_neg8",  64'(neg8),  64'd0);
    check("rst_bcd8",  64'(bcd8),  64'd0);
    check("rst_bcd16", 64'(bcd16), 64'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_conv(1'b0, tbl[i].sig, {8'h0, tbl[i].data}, r_bcd, r_neg, lat);
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'd8);
      check($sformatf("tbl%0d_bcd", i), 64'(r_bcd[11:0]), 64'(tbl[i].exp_bcd));
      check($sformatf("tbl%0d_neg", i), 64'(r_neg), 64'(tbl[i].exp_neg));
    end

    // start held high across a conversion, data changes mid-flight, back-to-back accept
    @(negedge clk);
    start8 = 1'b1; sig8 = 1'b0; data8 = 8'd42;
    @(negedge clk);
    data8 = 8'd7;
    k = 0;
    while (!done8 && k < 40) begin @(negedge clk); k++; end
    check("b2b_first_lat", 64'(k), 64'd8);
    check("b2b_first_bcd", 64'(bcd8), 64'h042);
    @(negedge clk);
    check("b2b_no_idle_busy", 64'(busy8), 64'd1);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin @(negedge clk); k++; end
    check("b2b_second_lat", 64'(k), 64'd8);
    check("b2b_second_bcd", 64'(bcd8), 64'h007);

    // asynchronous reset during cycle 4 of CONVERT
    @(negedge clk);
    start8 = 1'b1; data8 = 8'd200;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_bcd",  64'(bcd8),  64'd0);
    check("abort_neg",  64'(neg8),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) seen = 1'b1; end
    check("abort_no_done", 64'(seen), 64'd0);
    do_conv(1'b0, 1'b0, 16'd99, r_bcd, r_neg, lat);
    check("after_abort_bcd", 64'(r_bcd[11:0]), 64'h099);

    // 16-bit instance
    do_conv(1'b1, 1'b0, 16'hFFFF, r_bcd, r_neg, lat);
    check("w16_max_lat", 64'(lat), 64'd16);
    check("w16_max_bcd", 64'(r_bcd), 64'h65535);
    check("w16_max_neg", 64'(r_neg), 64'd0);
    do_conv(1'b1, 1'b1, 16'h8000, r_bcd, r_neg, lat);
    check("w16_min_bcd", 64'(r_bcd), 64'h32768);
    check("w16_min_neg", 64'(r_neg), 64'd1);

    // random 8-bit: operands summed as by the adder, checked by magnitude and end-to-end decimal
    for (int i = 0; i < 100; i++) begin
      logic [7:0]        a, b, sum;
      logic signed [7:0] ssum;
      bit                s;
      int unsigned       mag;
      string             exp_str;
      a    = 8'($urandom);
      b    = 8'($urandom);
      s    = 1'($urandom);
      sum  = a + b;
      ssum = $signed(sum);
      mag  = (s && sum[7]) ? (256 - int'(sum)) : int'(sum);
      exp_str = s ? $sformatf("%0d", ssum) : $sformatf("%0d", sum);
      do_conv(1'b0, s, {8'h0, sum}, r_bcd, r_neg, lat);
      check($sformatf("rnd8_%0d_bcd", i), 64'(r_bcd), 64'(dec_to_bcd(mag)));
      check($sformatf("rnd8_%0d_neg", i), 64'(r_neg), 64'(s && sum[7]));
      check_str($sformatf("rnd8_%0d_e2e", i), bcd_to_str(r_bcd, r_neg, 3), exp_str);
    end

    // random 16-bit
    for (int i = 0; i < 100; i++) begin
      logic [15:0] d;
      bit          s;
      int unsigned mag;
      d   = 16'($urandom);
      s   = 1'($urandom);
      mag = (s && d[15]) ? (65536 - int'(d)) : int'(d);
      do_conv(1'b1, s, d, r_bcd, r_neg, lat);
      check($sformatf("rnd16_%0d_bcd", i), 64'(r_bcd), 64'(dec_to_bcd(mag)));
      check($sformatf("rnd16_%0d_neg", i), 64'(r_neg), 64'(s && d[15]));
      check($sformatf("rnd16_%0d_lat", i), 64'(lat), 64'd16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
